// File: rtl/axi_pkg.sv
// Shared constants and types for the AXI-Lite register responder.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int unsigned NUM_CTRL   = 4;
  localparam int unsigned NUM_STATUS = 4;

  typedef enum logic [0:0] {
    W_IDLE,
    W_RESP
  } wr_state_e;

  function automatic logic [1:0] resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_wstrb_merge.sv
// Byte-lane merge: lanes with strobe set take the new word, the rest keep the old one.
module axi_wstrb_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strobe,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/axi_reg_responder.sv
// AXI-Lite slave exposing four byte-writable control registers and four read-only
// status words in a 32-byte window; one outstanding transaction per direction.
module axi_reg_responder
  import axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           CTRL_RESET = 32'h0
) (
  input  logic                  AXI_CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] AXI_awaddr,
  input  logic                  AXI_awvalid,
  output logic                  AXI_awready,
  input  logic [31:0]           AXI_wdata,
  input  logic [3:0]            AXI_wstrb,
  input  logic                  AXI_wvalid,
  output logic                  AXI_wready,
  output logic [1:0]            AXI_bresp,
  output logic                  AXI_bvalid,
  input  logic                  AXI_bready,
  input  logic [ADDR_WIDTH-1:0] AXI_araddr,
  input  logic                  AXI_arvalid,
  output logic                  AXI_arready,
  output logic [31:0]           AXI_rdata,
  output logic [1:0]            AXI_rresp,
  output logic                  AXI_rvalid,
  input  logic                  AXI_rready,
  output logic [127:0]          ctrl_regs,
  input  logic [127:0]          status_regs,
  output logic [3:0]            wr_pulse
);

  wr_state_e state_q, state_d;

  // Holds every ready low until the first edge after reset is released.
  logic                          ready_en_q;
  logic                          aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:2]         awaddr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic [1:0]                    bresp_q;
  logic [NUM_CTRL-1:0][31:0]     ctrl_q;
  logic [3:0]                    wr_pulse_q;
  logic                          rvalid_q;
  logic [31:0]                   rdata_q;
  logic [1:0]                    rresp_q;
  logic [NUM_STATUS-1:0][31:0]   status_w;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [2:0]  aw_idx, ar_idx;
  logic        aw_ok, ar_in_win;
  logic [31:0] merged;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AXI_awaddr[1:0], AXI_araddr[1:0]};

  assign status_w = status_regs;
  assign aw_hs    = AXI_awvalid & AXI_awready;
  assign w_hs     = AXI_wvalid & AXI_wready;
  assign ar_hs    = AXI_arvalid & AXI_arready;
  assign commit   = (state_q == W_IDLE) & aw_held_q & w_held_q;

  assign aw_idx    = awaddr_q[4:2];
  assign aw_ok     = (awaddr_q[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]) & ~aw_idx[2];
  assign ar_idx    = AXI_araddr[4:2];
  assign ar_in_win = AXI_araddr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];

  axi_wstrb_merge u_merge (
    .old_word (ctrl_q[aw_idx[1:0]]),
    .new_word (wdata_q),
    .strobe   (wstrb_q),
    .merged   (merged)
  );

  always_ff @(posedge AXI_CLK) begin
    if (RESET) state_q <= W_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE:  if (commit)     state_d = W_RESP;
      W_RESP:  if (AXI_bready) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AXI_awready = ready_en_q & ~aw_held_q & (state_q == W_IDLE);
    AXI_wready  = ready_en_q & ~w_held_q & (state_q == W_IDLE);
    AXI_bvalid  = (state_q == W_RESP);
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      ctrl_q     <= {NUM_CTRL{CTRL_RESET}};
      wr_pulse_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= AXI_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= AXI_wdata;
        wstrb_q  <= AXI_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= resp_of(aw_ok);
        if (aw_ok && wstrb_q != 4'b0) begin
          ctrl_q[aw_idx[1:0]]     <= merged;
          wr_pulse_q[aw_idx[1:0]] <= 1'b1;
        end
      end
    end
  end

  // Read data is captured at the handshake edge, so a same-edge commit is not visible.
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (!ar_in_win) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end else begin
        rdata_q <= ar_idx[2] ? status_w[ar_idx[1:0]] : ctrl_q[ar_idx[1:0]];
        rresp_q <= RESP_OKAY;
      end
    end else if (rvalid_q && AXI_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign AXI_arready = ready_en_q & ~rvalid_q;
  assign AXI_rvalid  = rvalid_q;
  assign AXI_rdata   = rdata_q;
  assign AXI_rresp   = rresp_q;
  assign AXI_bresp   = bresp_q;
  assign ctrl_regs   = ctrl_q;
  assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_axi_reg_responder.sv
// Directed scenario tests for axi_reg_responder with hand-computed expectations.
module tb_axi_reg_responder;

  localparam logic [31:0] CR = 32'hA5A5_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [3:0]   wstrb, wr_pulse;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] ctrl_regs, status_regs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_reg_responder #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0),
    .CTRL_RESET (CR)
  ) dut (
    .AXI_CLK     (clk),
    .RESET       (rst),
    .AXI_awaddr  (awaddr),
    .AXI_awvalid (awvalid),
    .AXI_awready (awready),
    .AXI_wdata   (wdata),
    .AXI_wstrb   (wstrb),
    .AXI_wvalid  (wvalid),
    .AXI_wready  (wready),
    .AXI_bresp   (bresp),
    .AXI_bvalid  (bvalid),
    .AXI_bready  (bready),
    .AXI_araddr  (araddr),
    .AXI_arvalid (arvalid),
    .AXI_arready (arready),
    .AXI_rdata   (rdata),
    .AXI_rresp   (rresp),
    .AXI_rvalid  (rvalid),
    .AXI_rready  (rready),
    .ctrl_regs   (ctrl_regs),
    .status_regs (status_regs),
    .wr_pulse    (wr_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same-cycle AW+W with BREADY high; returns after the response has drained.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bready = 1'b1;
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (awready !== 1'b0) begin failures++; $display("FAIL reset_awready got=%b exp=0", awready); end
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b exp=0", wready); end
    checks++; if (arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b exp=0", arready); end
    checks++; if ({bvalid, rvalid} !== 2'b00) begin failures++; $display("FAIL reset_valids got=%b exp=00", {bvalid, rvalid}); end
    checks++; if (wr_pulse !== 4'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0000", wr_pulse); end
    checks++; if ({bresp, rresp, rdata} !== 36'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", {bresp, rresp, rdata}); end
    checks++; if (ctrl_regs !== {4{CR}}) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl_regs, {4{CR}}); end
    rst = 1'b0;
    #2;
    checks++; if (awready !== 1'b0) begin failures++; $display("FAIL ready_early got=%b exp=0", awready); end
    tick();
    checks++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL ready_rise got=%b exp=111", {awready, wready, arready}); end
  endtask

  task automatic test_same_cycle();
    bready = 1'b1;
    awaddr = 32'h04; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL sc_bvalid_early got=%b exp=0", bvalid); end
    tick();
    checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL sc_bvalid got=%b exp=1", bvalid); end
    checks++; if (bresp !== 2'b00) begin failures++; $display("FAIL sc_bresp got=%b exp=00", bresp); end
    checks++; if (ctrl_regs[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL sc_reg1 got=%h exp=deadbeef", ctrl_regs[63:32]); end
    checks++; if (wr_pulse !== 4'b0010) begin failures++; $display("FAIL sc_pulse got=%b exp=0010", wr_pulse); end
    tick();
    checks++; if ({bvalid, wr_pulse} !== 5'b0) begin failures++; $display("FAIL sc_after got=%b exp=00000", {bvalid, wr_pulse}); end
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL sc_awready got=%b exp=1", awready); end
  endtask

  task automatic test_w_first();
    do_write(32'h08, 32'h11223344, 4'hF);
    bready = 1'b0;
    wdata = 32'h0000AA00; wstrb = 4'b0010; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick(); tick();
    checks++; if ({wready, bvalid} !== 2'b00) begin failures++; $display("FAIL wf_wait got=%b exp=00", {wready, bvalid}); end
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL wf_bvalid_early got=%b exp=0", bvalid); end
    tick();
    checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL wf_bvalid got=%b exp=1", bvalid); end
    checks++; if (ctrl_regs[95:64] !== 32'h1122AA44) begin failures++; $display("FAIL wf_reg2 got=%h exp=1122aa44", ctrl_regs[95:64]); end
    checks++; if (wr_pulse !== 4'b0100) begin failures++; $display("FAIL wf_pulse got=%b exp=0100", wr_pulse); end
    tick(); tick();
    checks++; if ({bvalid, bresp, awready, wr_pulse} !== 8'b1_00_0_0000) begin failures++; $display("FAIL wf_hold got=%b exp=10000000", {bvalid, bresp, awready, wr_pulse}); end
    bready = 1'b1;
    tick();
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL wf_drain got=%b exp=0", bvalid); end
  endtask

  task automatic test_slverr();
    logic [31:0] bad [2];
    bad[0] = 32'h14; bad[1] = 32'h40;
    bready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awaddr = bad[i]; awvalid = 1'b1;
      wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      checks++; if ({bvalid, bresp} !== 3'b1_10) begin failures++; $display("FAIL se_bresp_%0d got=%b exp=110", i, {bvalid, bresp}); end
      checks++; if (wr_pulse !== 4'b0) begin failures++; $display("FAIL se_pulse_%0d got=%b exp=0000", i, wr_pulse); end
      checks++; if (ctrl_regs !== {CR, 32'h1122AA44, 32'hDEADBEEF, CR}) begin failures++; $display("FAIL se_ctrl_%0d got=%h", i, ctrl_regs); end
      tick();
    end
    araddr = 32'h40; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    checks++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin failures++; $display("FAIL se_read got=%b/%b/%h exp=1/10/0", rvalid, rresp, rdata); end
    rready = 1'b1;
    tick();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL se_rdrain got=%b exp=0", rvalid); end
    rready = 1'b0;
  endtask

  task automatic test_zero_strobe();
    bready = 1'b1;
    awaddr = 32'h04; awvalid = 1'b1;
    wdata = 32'h12345678; wstrb = 4'h0; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    checks++; if ({bvalid, bresp, wr_pulse} !== 7'b1_00_0000) begin failures++; $display("FAIL zs_resp got=%b exp=1000000", {bvalid, bresp, wr_pulse}); end
    checks++; if (ctrl_regs[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL zs_reg1 got=%h exp=deadbeef", ctrl_regs[63:32]); end
    tick();
  endtask

  task automatic test_read_hold();
    status_regs = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h00000000};
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    status_regs = '1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rh_rvalid_%0d got=%b exp=1", i, rvalid); end
      checks++; if (rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rh_rdata_%0d got=%h exp=cafef00d", i, rdata); end
      checks++; if (arready !== 1'b0) begin failures++; $display("FAIL rh_arready_%0d got=%b exp=0", i, arready); end
      tick();
    end
    checks++; if (rresp !== 2'b00) begin failures++; $display("FAIL rh_rresp got=%b exp=00", rresp); end
    rready = 1'b1;
    tick();
    checks++; if ({rvalid, arready} !== 2'b01) begin failures++; $display("FAIL rh_drain got=%b exp=01", {rvalid, arready}); end
    rready = 1'b0;
  endtask

  task automatic test_read_write_same_edge();
    do_write(32'h00, 32'h1, 4'hF);
    awaddr = 32'h00; awvalid = 1'b1;
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h00; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    checks++; if ({rvalid, rdata} !== {1'b1, 32'h1}) begin failures++; $display("FAIL rw_rdata got=%b/%h exp=1/00000001", rvalid, rdata); end
    checks++; if (ctrl_regs[31:0] !== 32'h5) begin failures++; $display("FAIL rw_reg0 got=%h exp=00000005", ctrl_regs[31:0]); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bready = 1'b1;
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0) begin failures++; $display("FAIL rm_aw_held got=%b exp=0", awready); end
    rst = 1'b1;
    tick();
    checks++; if ({bvalid, awready, wready} !== 3'b000) begin failures++; $display("FAIL rm_flags got=%b exp=000", {bvalid, awready, wready}); end
    checks++; if (ctrl_regs !== {4{CR}}) begin failures++; $display("FAIL rm_ctrl got=%h exp=%h", ctrl_regs, {4{CR}}); end
    rst = 1'b0;
    tick();
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL rm_aw_dropped got=%b exp=1", awready); end
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    checks++; if ({bvalid, wready} !== 2'b00) begin failures++; $display("FAIL rm_no_commit got=%b exp=00", {bvalid, wready}); end
    checks++; if (ctrl_regs[127:96] !== CR) begin failures++; $display("FAIL rm_reg3 got=%h exp=%h", ctrl_regs[127:96], CR); end
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    checks++; if ({bvalid, wr_pulse} !== 5'b1_1000) begin failures++; $display("FAIL rm_late_commit got=%b exp=11000", {bvalid, wr_pulse}); end
    checks++; if (ctrl_regs[127:96] !== 32'h77) begin failures++; $display("FAIL rm_reg3_new got=%h exp=00000077", ctrl_regs[127:96]); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    status_regs = '0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_slverr();
    test_zero_strobe();
    test_read_hold();
    test_read_write_same_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_reg_responder.md
AXI_REG_RESPONDER -- requirements
Module: axi_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, window base, 32-byte aligned.
REQ-003 SHALL have parameter CTRL_RESET, default 32'h0, reset value of every control register.
REQ-004 AXI_CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 AXI_awaddr in ADDR_WIDTH; AXI_awvalid in 1; AXI_awready out 1  write-address channel.
REQ-007 AXI_wdata in 32; AXI_wstrb in 4; AXI_wvalid in 1; AXI_wready out 1  write-data channel.
REQ-008 AXI_bresp out 2; AXI_bvalid out 1; AXI_bready in 1  write-response channel.
REQ-009 AXI_araddr in ADDR_WIDTH; AXI_arvalid in 1; AXI_arready out 1  read-address channel.
REQ-010 AXI_rdata out 32; AXI_rresp out 2; AXI_rvalid out 1; AXI_rready in 1  read-data channel.
REQ-011 ctrl_regs  out  128  control registers 0..3, reg n on bits [32n+31:32n].
REQ-012 status_regs  in  128  read-only status words 4..7, word n-4 on bits [32(n-4)+31:32(n-4)].
REQ-013 wr_pulse  out  4  one-cycle strobe per control register on commit.

Function
REQ-014 Register index SHALL be addr[4:2]; addr[1:0] ignored; addr[ADDR_WIDTH-1:5] != BASE_ADDR[ADDR_WIDTH-1:5] → out of window.
REQ-015 AWREADY SHALL be 1 iff no AW held and BVALID=0; WREADY 1 iff no W held and BVALID=0.
REQ-016 AW and W SHALL be accepted independently, in either order or the same cycle, each latched on handshake.
REQ-017 At the first edge with both AW and W held, the block SHALL commit: byte lanes with wstrb[i]=1 updated, others kept; BVALID←1; held flags cleared.
REQ-018 Commit latency SHALL be one cycle: handshake of the later channel at edge N → register update and BVALID=1 after edge N+1.
REQ-019 BRESP SHALL be 2'b00 for index 0..3 in window; 2'b10 (SLVERR) for index 4..7 or out of window, with no state change.
REQ-020 BVALID SHALL hold, with BRESP stable, until BREADY=1, then clear at that edge.
REQ-021 wr_pulse[n] SHALL be high exactly the cycle after commit to reg n with wstrb!=0; wstrb=0 → OKAY, no change, no pulse.
REQ-022 ARREADY SHALL equal !RVALID; on AR handshake at edge N, RDATA/RRESP/RVALID=1 valid from edge N (one-cycle latency).
REQ-023 Read of index 0..3 SHALL return ctrl value at edge N (pre-commit if a write commits the same edge); index 4..7 returns status_regs sampled at edge N; RRESP 2'b00.
REQ-024 Out-of-window read SHALL return RDATA=0, RRESP=2'b10.
REQ-025 RVALID SHALL hold, with RDATA stable, until RREADY=1, then clear.
REQ-026 Read and write channels SHALL operate concurrently; one outstanding transaction per direction.

Reset
REQ-027 RESET=1 at an edge SHALL set ctrl_regs to CTRL_RESET; AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse to 0; BRESP, RRESP, RDATA to 0.
REQ-028 Reset mid-transaction SHALL discard held AW/W and pending B/R responses without commit.
REQ-029 Ready outputs SHALL first rise the cycle after RESET deasserts.

Structure
REQ-030 Shared package axi_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, NUM_CTRL=4, NUM_STATUS=4.
REQ-031 Byte-lane merge SHALL be sub-module axi_wstrb_merge (old word, new word, strobe → merged word).
REQ-032 Write path SHALL be a state machine W_IDLE (collecting AW/W) → W_RESP (BVALID) → W_IDLE on BREADY.

Verification
REQ-033 AW 0x04 and W 0xDEADBEEF/4'hF same cycle, BREADY=1 → ctrl reg1=0xDEADBEEF, BRESP 00, wr_pulse=4'b0010 once.
REQ-034 W 0x0000AA00/4'b0010 three cycles before AW 0x08, reg2=0x11223344 → reg2=0x1122AA44, BVALID after AW+1.
REQ-035 Write 0x14 or 0x40 → BRESP 10, ctrl_regs unchanged, no pulse; read 0x40 → RDATA 0, RRESP 10.
REQ-036 status_regs word1=0xCAFEF00D, read 0x14 with RREADY low 5 cycles → RVALID held, RDATA stable 0xCAFEF00D, ARREADY 0.
REQ-037 Read 0x00 and commit write 0x00=0x5 same edge, reg0=0x1 → RDATA 0x1, reg0 then 0x5.
REQ-038 RESET pulse while AW held, W pending → no commit, BVALID 0, ctrl_regs=CTRL_RESET.
